// File: rtl/sym_round_ctrl.sv
// Round sequencer: picks a target, presents NUM_SYMS LFSR symbols paced by Tick, counts target hits, grades the answer.
// Start->first SymValid 2 cycles, AnswerValid->Done 1 cycle; no backpressure, WAIT_ANS stalls indefinitely for the answer.
module sym_round_ctrl #(
    parameter int         NUM_SYMS   = 16,
    parameter int         HOLD_TICKS = 4,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       tick_i,
    input  logic       answer_valid_i,
    input  logic [4:0] answer_i,
    output logic [3:0] target_index_o,
    output logic [3:0] sym_index_o,
    output logic       sym_valid_o,
    output logic       busy_o,
    output logic [4:0] target_count_o,
    output logic       done_o,
    output logic       correct_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHOW,
        WAIT_ANS,
        RESULT
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);
    localparam logic [4:0] SHOWN_LAST = 5'(NUM_SYMS - 1);

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] target_q, target_d;
    logic [3:0] sym_q, sym_d;
    logic [4:0] count_q, count_d;
    logic [7:0] hold_q, hold_d;
    logic [4:0] shown_q, shown_d;
    logic       correct_q, correct_d;
    logic [3:0] rnd;

    assign rnd = lfsr_q[3:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            target_q  <= 4'd0;
            sym_q     <= 4'd0;
            count_q   <= 5'd0;
            hold_q    <= 8'd0;
            shown_q   <= 5'd0;
            correct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            target_q  <= target_d;
            sym_q     <= sym_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            shown_q   <= shown_d;
            correct_q <= correct_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        // x^8+x^6+x^5+x^4+1, free-running in every state
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        target_d  = target_q;
        sym_d     = sym_q;
        count_d   = count_q;
        hold_d    = hold_q;
        shown_d   = shown_q;
        correct_d = correct_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    target_d  = rnd;
                    count_d   = 5'd0;
                    shown_d   = 5'd0;
                    correct_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                sym_d  = rnd;
                hold_d = 8'd0;
                if (rnd == target_q) begin
                    count_d = count_q + 5'd1;
                end
                state_d = SHOW;
            end
            SHOW: begin
                if (tick_i) begin
                    if (hold_q == HOLD_LAST) begin
                        if (shown_q == SHOWN_LAST) begin
                            state_d = WAIT_ANS;
                        end else begin
                            shown_d = shown_q + 5'd1;
                            state_d = LOAD;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
            WAIT_ANS: begin
                if (answer_valid_i) begin
                    correct_d = (answer_i == count_q);
                    state_d   = RESULT;
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign target_index_o = target_q;
    assign sym_index_o    = sym_q;
    assign sym_valid_o    = (state_q == SHOW);
    assign busy_o         = (state_q != IDLE);
    assign target_count_o = count_q;
    assign done_o         = (state_q == RESULT);
    assign correct_o      = correct_q;

endmodule
